dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  Memory-stage consumer of the ALU->DMEM pipeline register outputs. Turns memr/memw plus address
//  (alu_result), store data (rs2val) and funct3 into one valid/ready request on the 64-bit data bus.
//  Holds the pipeline via stall until the bus responds. Returns the aligned, sign/zero-extended load
//  value, or the ALU result passed through, toward the DMEM->WB register.
// PARAMETERS
//  XLEN            64  datapath/address width; only 64 supported
//  TIMEOUT_CYCLES  0   max cycles in RESP before bus_err; 0 = no timeout
// PORTS
//  clk                 in   1   clock, single domain
//  rst                 in   1   reset, synchronous, active-high
//  memr_to_dmem        in   1   load in stage
//  memw_to_dmem        in   1   store in stage (memr&memw together never occurs; memr wins)
//  funct3_to_dmem      in   3   access size/sign (RV64 load/store funct3)
//  alu_result_to_dmem  in   64  effective address / non-mem result
//  rs2val_to_dmem      in   64  store data, LSB-aligned
//  stall               out  1   low = pipeline regs may advance (drives their enable inverted)
//  dmem_result         out  64  value toward WB
//  misalign            out  1   1-cycle pulse: misaligned access dropped
//  bus_err             out  1   1-cycle pulse: timeout expired
//  dbus_req_valid      out  1   request valid
//  dbus_req_ready      in   1   request accepted when valid&ready
//  dbus_req_addr       out  64  {addr[63:3],3'b0}
//  dbus_req_we         out  1   1 = store
//  dbus_req_wdata      out  64  rs2val << (addr[2:0]*8)
//  dbus_req_wstrb      out  8   size mask << addr[2:0]
//  dbus_resp_valid     in   1   response (loads and stores both get one)
//  dbus_resp_rdata     in   64  aligned 8-byte read data
// BEHAVIOUR
//  FSM IDLE/REQ/RESP; reset -> IDLE, all registered outputs 0, req fields 0, timeout counter 0.
//  IDLE: mem op && aligned -> latch addr/we/wdata/wstrb/funct3, go REQ; stall=1 combinationally.
//        mem op && misaligned -> misalign=1 this cycle, no request, stall=0, stay IDLE.
//        no mem op -> stall=0, dmem_result=alu_result_to_dmem.
//  REQ:  dbus_req_valid=1; req fields stable; stall=1; valid&ready -> RESP. valid never drops before ready.
//  RESP: stall=!dbus_resp_valid. On resp_valid: dmem_result=ext(rdata>>(addr[2:0]*8)) (loads) or
//        alu_result (stores), same cycle; go IDLE. The following instr is seen next cycle.
//  ext: 000 LB, 001 LH, 010 LW, 011 LD sign-extend; 100 LBU, 101 LHU, 110 LWU zero-extend; 111 -> LD.
//  size mask: B 8'h01, H 8'h03, W 8'h0F, D 8'hFF. Aligned iff addr % size == 0.
//  Timeout: counter counts cycles in RESP when TIMEOUT_CYCLES>0; reaching TIMEOUT_CYCLES -> bus_err
//        pulse, dmem_result=0, stall=0, go IDLE. Counter clears on RESP entry.
//  resp_valid outside RESP is ignored. Min op latency: 3 cycles (IDLE, REQ+ready, RESP+resp_valid).
//  Reset mid-op: IDLE next cycle, req_valid=0, stall=0; a late response is ignored.
//  While stall=1 upstream inputs stay constant (enable low); FSM samples only in IDLE.
// TESTING
//  LB addr 0x1003, rdata 0x0000_0000_80_000000, ready/resp immediate -> req_addr 0x1000,
//    wstrb 0, dmem_result 0xFFFF_FFFF_FFFF_FF80, stall high for 2 cycles.
//  SW addr 0x2004, rs2 0x1122_3344_5566_7788 -> wdata 0x5566_7788_0000_0000, wstrb 0xF0, we=1.
//  LH addr 0x3001 -> misalign pulse, dbus_req_valid stays 0, stall 0.
//  ready held low 5 cycles then high; resp 3 cycles later -> req fields stable throughout, stall 9 cycles.
//  TIMEOUT_CYCLES=4, no response -> bus_err after 4 RESP cycles, dmem_result 0, back to IDLE.
//  rst asserted in RESP, then resp_valid arrives -> ignored; stall 0; next LD issues normally.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Memory-stage access unit: turns a load/store in the DMEM stage into one valid/ready bus
// transaction, stalls the pipeline until the response arrives, and returns the extended load value.
`timescale 1ns/1ps

module dmem_access_unit #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memr_to_dmem,
    input  logic            memw_to_dmem,
    input  logic [2:0]      funct3_to_dmem,
    input  logic [XLEN-1:0] alu_result_to_dmem,
    input  logic [XLEN-1:0] rs2val_to_dmem,
    output logic            stall,
    output logic [XLEN-1:0] dmem_result,
    output logic            misalign,
    output logic            bus_err,
    output logic            dbus_req_valid,
    input  logic            dbus_req_ready,
    output logic [XLEN-1:0] dbus_req_addr,
    output logic            dbus_req_we,
    output logic [XLEN-1:0] dbus_req_wdata,
    output logic [7:0]      dbus_req_wstrb,
    input  logic            dbus_resp_valid,
    input  logic [XLEN-1:0] dbus_resp_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] req_wdata_q;
    logic            req_we_q;
    logic [7:0]      req_wstrb_q;
    logic [2:0]      funct3_q;
    logic [31:0]     tmo_cnt_q;

    logic            mem_op;
    logic            is_store;
    logic            aligned;
    logic            start;
    logic            timeout_hit;
    logic [2:0]      offset;
    logic [7:0]      size_mask;
    logic [XLEN-1:0] load_value;

    // Byte lanes are selected from the bus word, then narrowed and extended per funct3.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [2:0]      off,
                                                    input logic [2:0]      f3);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  load_extend = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b100:  load_extend = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  load_extend = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'b110:  load_extend = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: load_extend = sh;
        endcase
    endfunction

    assign mem_op     = memr_to_dmem | memw_to_dmem;
    assign is_store   = memw_to_dmem & ~memr_to_dmem;
    assign offset     = alu_result_to_dmem[2:0];
    assign start      = mem_op & aligned;
    assign load_value = load_extend(dbus_resp_rdata, req_addr_q[2:0], funct3_q);

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == ST_RESP) && !dbus_resp_valid &&
                         (tmo_cnt_q == TMO_LAST);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        size_mask = 8'h01;
        aligned   = 1'b1;
        case (funct3_to_dmem[1:0])
            2'b01: begin size_mask = 8'h03; aligned = (offset[0] == 1'b0);   end
            2'b10: begin size_mask = 8'h0F; aligned = (offset[1:0] == 2'b00); end
            2'b11: begin size_mask = 8'hFF; aligned = (offset == 3'b000);     end
            default: begin size_mask = 8'h01; aligned = 1'b1; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        misalign    = 1'b0;
        bus_err     = 1'b0;
        dmem_result = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    state_d = ST_REQ;
                end else if (mem_op) begin
                    misalign = 1'b1;
                end else begin
                    dmem_result = alu_result_to_dmem;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (dbus_req_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (dbus_resp_valid) begin
                    dmem_result = req_we_q ? alu_result_to_dmem : load_value;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    bus_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
            req_wstrb_q <= 8'h00;
            funct3_q    <= 3'b000;
            tmo_cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                req_addr_q  <= alu_result_to_dmem;
                req_we_q    <= is_store;
                req_wdata_q <= is_store ? (rs2val_to_dmem << {offset, 3'b000}) : '0;
                req_wstrb_q <= is_store ? (size_mask << offset) : 8'h00;
                funct3_q    <= funct3_to_dmem;
            end
            // Cleared while the request is pending so the count starts at zero on RESP entry.
            if (state_q == ST_REQ) begin
                tmo_cnt_q <= 32'd0;
            end else if (state_q == ST_RESP && TIMEOUT_CYCLES > 0) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end
        end
    end

    assign dbus_req_valid = (state_q == ST_REQ);
    assign dbus_req_addr  = {req_addr_q[XLEN-1:3], 3'b000};
    assign dbus_req_we    = req_we_q;
    assign dbus_req_wdata = req_wdata_q;
    assign dbus_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: a driver plays loads/stores and a bus responder, a
// monitor compares bus requests and stage results against expectations from a byte-level model.
`timescale 1ns/1ps

module tb_dmem_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        memr_to_dmem;
    logic        memw_to_dmem;
    logic [2:0]  funct3_to_dmem;
    logic [63:0] alu_result_to_dmem;
    logic [63:0] rs2val_to_dmem;
    logic        stall;
    logic [63:0] dmem_result;
    logic        misalign;
    logic        bus_err;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [63:0] dbus_req_addr;
    logic        dbus_req_we;
    logic [63:0] dbus_req_wdata;
    logic [7:0]  dbus_req_wstrb;
    logic        dbus_resp_valid;
    logic [63:0] dbus_resp_rdata;

    dmem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .memr_to_dmem       (memr_to_dmem),
        .memw_to_dmem       (memw_to_dmem),
        .funct3_to_dmem     (funct3_to_dmem),
        .alu_result_to_dmem (alu_result_to_dmem),
        .rs2val_to_dmem     (rs2val_to_dmem),
        .stall              (stall),
        .dmem_result        (dmem_result),
        .misalign           (misalign),
        .bus_err            (bus_err),
        .dbus_req_valid     (dbus_req_valid),
        .dbus_req_ready     (dbus_req_ready),
        .dbus_req_addr      (dbus_req_addr),
        .dbus_req_we        (dbus_req_we),
        .dbus_req_wdata     (dbus_req_wdata),
        .dbus_req_wstrb     (dbus_req_wstrb),
        .dbus_resp_valid    (dbus_resp_valid),
        .dbus_resp_rdata    (dbus_resp_rdata)
    );

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_exp_t;

    typedef struct {
        logic [63:0] result;
        logic        chk_result;
        logic        misalign;
        logic        bus_err;
        int          stall_cycles;
    } done_exp_t;

    req_exp_t  req_q[$];
    done_exp_t done_q[$];
    int        n_cmp = 0;
    int        n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference load: pick bytes at the offset, keep `size` bytes, sign-extend when signed.
    function automatic logic [63:0] load_model(input logic [63:0] rdata, input logic [63:0] addr,
                                               input logic [2:0] f3);
        int          size;
        bit          sgn;
        logic [63:0] v;
        logic [63:0] m;
        size = 1 << f3[1:0];
        sgn  = (f3[2] == 1'b0) || (f3 == 3'b111);
        v    = rdata >> (8 * int'(addr % 8));
        if (size < 8) begin
            m = (64'd1 << (8 * size)) - 64'd1;
            v = v & m;
            if (sgn && v[8*size-1]) v = v | ~m;
        end
        return v;
    endfunction

    // Monitor: every REQ cycle is compared to the head request; every non-stalled cycle completes one instruction.
    initial begin : monitor
        int        stall_run;
        req_exp_t  e;
        done_exp_t d;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_run = 0;
            end else begin
                if (dbus_req_valid) begin
                    if (req_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL req_unexpected: got request addr 0x%h, expected none (t=%0t)",
                                 dbus_req_addr, $time);
                    end else begin
                        e = req_q[0];
                        check("req_addr", dbus_req_addr, e.addr);
                        check("req_we", 64'(dbus_req_we), 64'(e.we));
                        check("req_wstrb", 64'(dbus_req_wstrb), 64'(e.wstrb));
                        if (e.we) check("req_wdata", dbus_req_wdata, e.wdata);
                        if (dbus_req_ready) void'(req_q.pop_front());
                    end
                end
                if (stall) begin
                    stall_run++;
                    check("pulse_in_stall", {62'd0, misalign, bus_err}, 64'd0);
                end else begin
                    if (done_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL done_unexpected: got completion result 0x%h, expected none (t=%0t)",
                                 dmem_result, $time);
                    end else begin
                        d = done_q.pop_front();
                        if (d.chk_result) check("dmem_result", dmem_result, d.result);
                        check("misalign", 64'(misalign), 64'(d.misalign));
                        check("bus_err", 64'(bus_err), 64'(d.bus_err));
                        check("stall_cycles", 64'(stall_run), 64'(d.stall_cycles));
                        check("req_valid_at_done", 64'(dbus_req_valid), 64'd0);
                    end
                    stall_run = 0;
                end
            end
        end
    end

    // One instruction, with the bus responder timeline folded in: ready after rdy_dly REQ cycles,
    // response after rsp_dly empty RESP cycles; tmo withholds it, do_rst resets in the first RESP cycle.
    task automatic do_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] rdata,
                         input int rdy_dly, input int rsp_dly, input bit tmo, input bit do_rst);
        int        size;
        int        off;
        bit        mem;
        bit        ok;
        req_exp_t  r;
        done_exp_t d;
        mem  = rd_op | wr_op;
        size = 1 << f3[1:0];
        off  = int'(addr % 8);
        ok   = (addr % 64'(size)) == 64'd0;
        d.result       = addr;
        d.chk_result   = 1'b1;
        d.misalign     = 1'b0;
        d.bus_err      = 1'b0;
        d.stall_cycles = 0;

        @(posedge clk); #1;
        memr_to_dmem       = rd_op;
        memw_to_dmem       = wr_op;
        funct3_to_dmem     = f3;
        alu_result_to_dmem = addr;
        rs2val_to_dmem     = rs2;
        dbus_req_ready     = 1'b0;
        dbus_resp_valid    = 1'($urandom_range(0, 1));
        dbus_resp_rdata    = {$urandom, $urandom};
        if (!mem) begin
            done_q.push_back(d);
            return;
        end
        if (!ok) begin
            d.chk_result = 1'b0;
            d.misalign   = 1'b1;
            done_q.push_back(d);
            return;
        end

        r.addr  = addr & ~64'h7;
        r.we    = !rd_op;
        r.wdata = rs2 << (8 * off);
        r.wstrb = r.we ? 8'(((1 << size) - 1) << off) : 8'h00;
        req_q.push_back(r);
        d.stall_cycles = 2 + rdy_dly + (tmo ? TMO - 1 : rsp_dly);
        if (tmo) begin
            d.result  = 64'd0;
            d.bus_err = 1'b1;
        end else if (rd_op) begin
            d.result = load_model(rdata, addr, f3);
        end
        if (!do_rst) done_q.push_back(d);

        repeat (rdy_dly) begin
            @(posedge clk); #1;
            dbus_resp_valid = 1'($urandom_range(0, 1));
            dbus_resp_rdata = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        dbus_req_ready  = 1'b1;
        dbus_resp_valid = 1'b0;

        if (do_rst) begin
            @(posedge clk); #1;
            dbus_req_ready = 1'b0;
            rst            = 1'b1;
            @(posedge clk); #1;
            rst                = 1'b0;
            memr_to_dmem       = 1'b0;
            memw_to_dmem       = 1'b0;
            alu_result_to_dmem = {$urandom, $urandom};
            dbus_resp_valid    = 1'b1;
            dbus_resp_rdata    = rdata;
            d.result       = alu_result_to_dmem;
            d.bus_err      = 1'b0;
            d.stall_cycles = 0;
            done_q.push_back(d);
            return;
        end

        if (tmo) begin
            repeat (TMO) begin
                @(posedge clk); #1;
                dbus_req_ready  = 1'b0;
                dbus_resp_valid = 1'b0;
            end
        end else begin
            repeat (rsp_dly) begin
                @(posedge clk); #1;
                dbus_req_ready  = 1'b0;
                dbus_resp_valid = 1'b0;
                dbus_resp_rdata = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            dbus_req_ready  = 1'b0;
            dbus_resp_valid = 1'b1;
            dbus_resp_rdata = rdata;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
        $fatal(1, "time limit");
    end

    initial begin : driver
        int          k;
        logic [2:0]  f3;
        logic [63:0] a;
        rst                = 1'b1;
        memr_to_dmem       = 1'b0;
        memw_to_dmem       = 1'b0;
        funct3_to_dmem     = 3'b000;
        alu_result_to_dmem = 64'h0;
        rs2val_to_dmem     = 64'h0;
        dbus_req_ready     = 1'b0;
        dbus_resp_valid    = 1'b0;
        dbus_resp_rdata    = 64'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 64'(dbus_req_valid), 64'd0);
        check("rst_req_addr", dbus_req_addr, 64'd0);
        check("rst_req_we", 64'(dbus_req_we), 64'd0);
        check("rst_req_wdata", dbus_req_wdata, 64'd0);
        check("rst_req_wstrb", 64'(dbus_req_wstrb), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_pulses", {62'd0, misalign, bus_err}, 64'd0);
        #1 rst = 1'b0;

        do_op(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0, 0);
        do_op(0, 1, 3'b010, 64'h2004, 64'h1122_3344_5566_7788, 64'h0, 0, 1, 0, 0);
        do_op(1, 0, 3'b001, 64'h3001, 64'h0, 64'h0, 0, 0, 0, 0);
        do_op(1, 0, 3'b011, 64'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 2, 0, 0);
        do_op(1, 0, 3'b011, 64'h5000, 64'h0, 64'h0, 0, 0, 1, 0);
        do_op(1, 0, 3'b011, 64'h6010, 64'h0, 64'hFEED_FACE_CAFE_BEEF, 1, 0, 0, 1);
        do_op(1, 0, 3'b011, 64'h7018, 64'h0, 64'h8877_6655_4433_2211, 0, 1, 0, 0);
        do_op(1, 0, 3'b110, 64'h7024, 64'h0, 64'hF000_0001_0000_0000, 0, 3, 0, 0);
        do_op(0, 1, 3'b000, 64'h7027, 64'h0000_0000_0000_00AB, 64'h0, 2, 0, 0, 0);
        do_op(0, 0, 3'b000, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            a = {$urandom, $urandom};
            if (k < 2) begin
                do_op(0, 0, 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, 64'h0, 0, 0, 0, 0);
            end else begin
                f3 = (k < 6) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
                do_op(k < 6, k >= 6, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            end
        end

        @(posedge clk); #1;
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
